// File: rtl/tensor_core_program_loader.sv
// tensor_core_program_loader
//
// Receives a framed byte stream from the host link, assembles it into 16-bit
// instructions and writes them sequentially into instruction memory. The
// tensor core is held in reset until a complete, checksum-verified program
// has been written.
//
// Frame: LEN_LO, LEN_HI, LEN words (low byte first), CHK.
// CHK is the XOR of every preceding byte in the frame.
//
// Ports:
//   clock_in            system clock, rising edge
//   reset_in            synchronous active-high reset
//   byte_valid_in       host byte available
//   byte_data_in        host byte
//   byte_ready_out      loader accepts a byte this cycle
//   clear_in            leaves DONE/ERROR for a new load (ignored elsewhere)
//   write_enable_out    one-cycle instruction memory write strobe
//   write_address_out   write address (holds until the next write)
//   write_data_out      instruction word (holds until the next write)
//   program_length_out  words written in the current frame
//   load_done_out       frame accepted with good checksum (sticky)
//   load_error_out      frame rejected (sticky)
//   core_reset_out      reset to tensor core and memory controller
module tensor_core_program_loader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned MAX_WORDS  = 20001
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  byte_valid_in,
  input  logic [7:0]            byte_data_in,
  output logic                  byte_ready_out,
  input  logic                  clear_in,
  output logic                  write_enable_out,
  output logic [ADDR_WIDTH-1:0] write_address_out,
  output logic [15:0]           write_data_out,
  output logic [ADDR_WIDTH-1:0] program_length_out,
  output logic                  load_done_out,
  output logic                  load_error_out,
  output logic                  core_reset_out
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, DATA_LO, DATA_HI, CHECK, DONE, ERROR
  } state_t;

  state_t                state, state_next;
  logic                  accept;
  logic [7:0]            lo_byte;
  logic [7:0]            xor_acc;
  logic [15:0]           frame_len;
  logic [15:0]           pair_word;
  logic [ADDR_WIDTH-1:0] word_count;
  logic                  last_word;

  // Ready depends on state only, so the host never sees a combinational
  // path from its own valid back into ready.
  assign byte_ready_out = (state != DONE) && (state != ERROR);
  assign accept         = byte_valid_in && byte_ready_out;

  // lo_byte holds either LEN_LO or the pending low data byte; pairing it with
  // the incoming byte yields both the frame length and each instruction word.
  assign pair_word = {byte_data_in, lo_byte};
  assign last_word = (32'(word_count) + 32'd1) == 32'(frame_len);

  assign program_length_out = word_count;
  assign load_done_out      = (state == DONE);
  assign load_error_out     = (state == ERROR);
  assign core_reset_out     = (state != DONE);

  always_ff @(posedge clock_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (32'(pair_word) > MAX_WORDS) state_next = ERROR;
          else if (pair_word == 16'd0)    state_next = CHECK;
          else                            state_next = DATA_LO;
        end
      end
      DATA_LO: if (accept) state_next = DATA_HI;
      DATA_HI: if (accept) state_next = last_word ? CHECK : DATA_LO;
      CHECK:   if (accept) state_next = (byte_data_in == xor_acc) ? DONE : ERROR;
      DONE:    if (clear_in) state_next = IDLE;
      ERROR:   if (clear_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: byte capture, running checksum, word counter and write port.
  // The write strobe is registered, so it lands one cycle after the high
  // byte is accepted, together with the incremented word count.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      lo_byte           <= '0;
      xor_acc           <= '0;
      frame_len         <= '0;
      word_count        <= '0;
      write_enable_out  <= 1'b0;
      write_address_out <= '0;
      write_data_out    <= '0;
    end else begin
      write_enable_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lo_byte <= byte_data_in;
            xor_acc <= byte_data_in;
          end
        end
        LEN_HI: begin
          if (accept) begin
            frame_len <= pair_word;
            xor_acc   <= xor_acc ^ byte_data_in;
          end
        end
        DATA_LO: begin
          if (accept) begin
            lo_byte <= byte_data_in;
            xor_acc <= xor_acc ^ byte_data_in;
          end
        end
        DATA_HI: begin
          if (accept) begin
            write_enable_out  <= 1'b1;
            write_address_out <= word_count;
            write_data_out    <= pair_word;
            word_count        <= word_count + 1'b1;
            xor_acc           <= xor_acc ^ byte_data_in;
          end
        end
        DONE, ERROR: begin
          if (clear_in) begin
            word_count <= '0;
            xor_acc    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_program_loader.sv
// Self-checking bench for tensor_core_program_loader: table of directed
// frames, hand-written multi-cycle sequences, and random frames compared
// against a frame-level reference model.
module tb_tensor_core_program_loader;

  localparam int AW   = 15;
  localparam int MAXW = 20001;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic          byte_valid_in;
  logic [7:0]    byte_data_in;
  logic          byte_ready_out;
  logic          clear_in;
  logic          write_enable_out;
  logic [AW-1:0] write_address_out;
  logic [15:0]   write_data_out;
  logic [AW-1:0] program_length_out;
  logic          load_done_out;
  logic          load_error_out;
  logic          core_reset_out;

  tensor_core_program_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clock_in(clock_in), .reset_in(reset_in),
    .byte_valid_in(byte_valid_in), .byte_data_in(byte_data_in),
    .byte_ready_out(byte_ready_out), .clear_in(clear_in),
    .write_enable_out(write_enable_out), .write_address_out(write_address_out),
    .write_data_out(write_data_out), .program_length_out(program_length_out),
    .load_done_out(load_done_out), .load_error_out(load_error_out),
    .core_reset_out(core_reset_out)
  );

  always #5 clock_in = ~clock_in;

  int tests = 0;
  int fails = 0;

  logic [7:0]  frame[$];
  logic [31:0] got_w[$];   // {addr, data} observed on the write port
  logic [31:0] m_w[$];     // {addr, data} expected by the model
  bit          m_done, m_err;
  int          m_plen;

  always @(negedge clock_in)
    if (write_enable_out === 1'b1)
      got_w.push_back({16'(write_address_out), write_data_out});

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Frame-level model: parse length, emit words in order, then judge CHK.
  task automatic run_model();
    int len;
    logic [7:0] x;
    m_w.delete();
    m_done = 0; m_err = 0; m_plen = 0;
    len = int'({frame[1], frame[0]});
    if (len > MAXW) begin
      m_err = 1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 2 * len; i++) x ^= frame[i];
    for (int w = 0; w < len; w++)
      m_w.push_back({16'(w), frame[3 + 2 * w], frame[2 + 2 * w]});
    m_plen = len;
    if (frame[2 + 2 * len] == x) m_done = 1;
    else                         m_err  = 1;
  endtask

  // Presents the queued bytes from a falling edge; stops once ready is low.
  task automatic send_frame(input int gap_max);
    logic rdy;
    for (int i = 0; i < frame.size(); i++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clock_in);
      byte_valid_in = 1'b1;
      byte_data_in  = frame[i];
      rdy = byte_ready_out;
      @(negedge clock_in);
      byte_valid_in = 1'b0;
      if (!rdy) break;
    end
  endtask

  task automatic check_writes(input string nm);
    check({nm, "_wrcnt"}, 32'(got_w.size()), 32'(m_w.size()));
    for (int i = 0; i < got_w.size() && i < m_w.size(); i++)
      check({nm, "_wr"}, got_w[i], m_w[i]);
  endtask

  task automatic check_result(input string nm, input bit d, input bit e, input int len);
    check({nm, "_done"}, 32'(load_done_out), 32'(d));
    check({nm, "_err"}, 32'(load_error_out), 32'(e));
    check({nm, "_plen"}, 32'(program_length_out), 32'(len));
    check({nm, "_corerst"}, 32'(core_reset_out), 32'(!d));
    check({nm, "_ready"}, 32'(byte_ready_out), 32'(!(d || e)));
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_ready"}, 32'(byte_ready_out), 32'd1);
    check({nm, "_done"}, 32'(load_done_out), 32'd0);
    check({nm, "_err"}, 32'(load_error_out), 32'd0);
    check({nm, "_plen"}, 32'(program_length_out), 32'd0);
    check({nm, "_corerst"}, 32'(core_reset_out), 32'd1);
  endtask

  task automatic pulse_clear();
    clear_in = 1'b1;
    @(negedge clock_in);
    clear_in = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [95:0] bytes;   // first byte in the most significant used position
    bit          exp_done;
    bit          exp_err;
    int          exp_len;
    int          gap;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [95:0] bb;

    // 02^00^34^12^CD^AB = 42, so 42 is the good checksum and E2 is bad.
    vecs[0] = '{"two_word",        7, 96'h02003412CDAB42, 1'b1, 1'b0, 2, 0};
    vecs[1] = '{"two_word_badchk", 7, 96'h02003412CDABE2, 1'b0, 1'b1, 2, 0};
    vecs[2] = '{"zero_len",        3, 96'h000000,         1'b1, 1'b0, 0, 0};
    vecs[3] = '{"zero_len_bad",    3, 96'h000001,         1'b0, 1'b1, 0, 0};
    vecs[4] = '{"too_long",        3, 96'h224E00,         1'b0, 1'b1, 0, 0};
    vecs[5] = '{"chk_err_one",     5, 96'h01007856FF,     1'b0, 1'b1, 1, 0};
    vecs[6] = '{"one_word_ok",     5, 96'h010078562F,     1'b1, 1'b0, 1, 0};
    vecs[7] = '{"two_word_stall",  7, 96'h02003412CDAB42, 1'b1, 1'b0, 2, 3};
    vecs[8] = '{"len_ffff",        3, 96'hFFFF00,         1'b0, 1'b1, 0, 0};

    reset_in = 1'b1; byte_valid_in = 1'b0; byte_data_in = 8'h00; clear_in = 1'b0;
    repeat (3) @(negedge clock_in);
    reset_in = 1'b0;
    check_idle("reset");
    check("reset_we", 32'(write_enable_out), 32'd0);
    check("reset_addr", 32'(write_address_out), 32'd0);
    check("reset_data", 32'(write_data_out), 32'd0);

    // Table-driven frames
    for (int k = 0; k < 9; k++) begin
      frame.delete();
      bb = vecs[k].bytes;
      for (int i = 0; i < vecs[k].n; i++) frame.push_back(bb[8 * (vecs[k].n - 1 - i) +: 8]);
      run_model();
      got_w.delete();
      send_frame(vecs[k].gap);
      @(negedge clock_in);
      check_result(vecs[k].name, vecs[k].exp_done, vecs[k].exp_err, vecs[k].exp_len);
      check_writes(vecs[k].name);
      pulse_clear();
      check_idle({vecs[k].name, "_clr"});
    end

    // Write timing: strobe one cycle after the high byte, data/addr hold,
    // clear ignored mid-frame, done rises right after the checksum byte.
    got_w.delete();
    frame = '{8'h02, 8'h00, 8'h34, 8'h12};
    send_frame(0);
    check("lat_we", 32'(write_enable_out), 32'd1);
    check("lat_addr", 32'(write_address_out), 32'd0);
    check("lat_data", 32'(write_data_out), 32'h1234);
    check("lat_plen", 32'(program_length_out), 32'd1);
    @(negedge clock_in);
    check("lat_we_drop", 32'(write_enable_out), 32'd0);
    check("lat_data_hold", 32'(write_data_out), 32'h1234);
    pulse_clear();
    check("midclr_ready", 32'(byte_ready_out), 32'd1);
    frame = '{8'hCD, 8'hAB, 8'h42};
    send_frame(0);
    check("lat_done", 32'(load_done_out), 32'd1);
    check("lat_corerst", 32'(core_reset_out), 32'd0);
    check("lat_wrcnt", 32'(got_w.size()), 32'd2);
    if (got_w.size() == 2) check("lat_wr1", got_w[1], 32'h0001ABCD);
    pulse_clear();

    // Reset mid-frame, with clear and a valid byte presented during reset.
    frame = '{8'h01, 8'h00, 8'h11};
    send_frame(0);
    reset_in = 1'b1; clear_in = 1'b1; byte_valid_in = 1'b1; byte_data_in = 8'h01;
    @(negedge clock_in);
    reset_in = 1'b0; clear_in = 1'b0; byte_valid_in = 1'b0;
    check_idle("midrst");
    check("midrst_addr", 32'(write_address_out), 32'd0);
    check("midrst_data", 32'(write_data_out), 32'd0);
    frame = '{8'h01, 8'h00, 8'hAA, 8'h55, 8'hFE};
    run_model();
    got_w.delete();
    send_frame(0);
    @(negedge clock_in);
    check_result("after_rst", 1'b1, 1'b0, 1);
    check_writes("after_rst");
    pulse_clear();

    // Random frames against the model
    for (int r = 0; r < 40; r++) begin
      int len;
      logic [7:0] x;
      frame.delete();
      if ($urandom_range(7, 0) == 0) len = $urandom_range(65535, MAXW + 1);
      else                           len = $urandom_range(6, 0);
      frame.push_back(8'(len));
      frame.push_back(8'(len >> 8));
      if (len > MAXW) begin
        frame.push_back(8'($urandom));
      end else begin
        for (int i = 0; i < 2 * len; i++) frame.push_back(8'($urandom));
        x = 8'h00;
        foreach (frame[i]) x ^= frame[i];
        if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
        frame.push_back(x);
      end
      run_model();
      got_w.delete();
      send_frame($urandom_range(2, 0));
      @(negedge clock_in);
      check_result("rand", m_done, m_err, m_plen);
      check_writes("rand");
      pulse_clear();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
